// File: rtl/derivative_lag_sv.sv
// ---------------------------------------------------------------------------
// derivative_lag_sv
//
// Multi-channel, valid-qualified discrete differentiator for the FM
// demodulator path. Each channel computes y[n] = x[n] - x[n-L], where the
// lag L is chosen at run time from 1..MAX_LAG. All channels share one
// control path (state, fill counter, stored lag); only the data path is
// replicated per channel.
//
// After reset, or after any lag change, the block sits in FILL until L valid
// samples have entered the history. The first output comes from sample L+1.
// Output latency is one clock. Output data is held between valid pulses.
//
// Optional feature macro: DERIV_SATURATE_EN
//   undefined : the DATA_WIDTH+1 bit difference wraps to DATA_WIDTH bits.
//   defined   : the difference saturates to the signed DATA_WIDTH range and
//               an extra output o_sat flags a clip on any channel.
//
// Ports:
//   i_sysclk_40        system clock (40 MHz)
//   i_rst_n            asynchronous active-low reset
//   i_valid            qualifies i_data (one sample per channel)
//   i_data             packed signed samples, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_lag              requested lag; 0 -> 1, values above MAX_LAG -> MAX_LAG
//   o_valid            qualifies o_derivative_data
//   o_derivative_data  packed signed differences, same packing as i_data
//   o_sat              (DERIV_SATURATE_EN only) some channel clipped on this sample
//   o_filling          high while in the FILL state
// ---------------------------------------------------------------------------
module derivative_lag_sv #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 2,
    parameter int MAX_LAG    = 8
) (
    input  logic                           i_sysclk_40,
    input  logic                           i_rst_n,
    input  logic                           i_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   i_data,
    input  logic [$clog2(MAX_LAG+1)-1:0]   i_lag,
    output logic                           o_valid,
    output logic [NUM_CH*DATA_WIDTH-1:0]   o_derivative_data,
`ifdef DERIV_SATURATE_EN
    output logic                           o_sat,
`endif
    output logic                           o_filling
);

    localparam int LAG_W = $clog2(MAX_LAG + 1);
    localparam logic [LAG_W-1:0] MAX_LAG_L = LAG_W'(MAX_LAG);

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Reduction of the full-precision difference back to DATA_WIDTH bits.
`ifdef DERIV_SATURATE_EN
    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // The value fits in DATA_WIDTH bits only if the two top bits agree.
    function automatic logic diff_clips(input logic signed [DATA_WIDTH:0] d);
        return d[DATA_WIDTH] != d[DATA_WIDTH-1];
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] reduce_diff(input logic signed [DATA_WIDTH:0] d);
        if (diff_clips(d))
            return d[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        return d[DATA_WIDTH-1:0];
    endfunction
`else
    function automatic logic signed [DATA_WIDTH-1:0] reduce_diff(input logic signed [DATA_WIDTH:0] d);
        return d[DATA_WIDTH-1:0];
    endfunction
`endif

    // Control state
    state_t             r_state;
    state_t             w_state_next;
    logic [LAG_W-1:0]   r_cnt;
    logic [LAG_W-1:0]   w_cnt_next;
    logic [LAG_W-1:0]   w_cnt_inc;
    logic [LAG_W-1:0]   r_lag;
    logic [LAG_W-1:0]   w_lag_eff;
    logic [LAG_W-1:0]   w_hist_idx;
    logic               w_lag_chg;
    logic               w_vld_next;

    // Data path
    logic signed [DATA_WIDTH-1:0]  r_hist [NUM_CH][MAX_LAG];
    logic [NUM_CH*DATA_WIDTH-1:0]  w_deriv;
    logic [NUM_CH*DATA_WIDTH-1:0]  r_data_p1;
    logic                          r_vld_p1;
`ifdef DERIV_SATURATE_EN
    logic                          w_clip;
    logic                          r_sat_p1;
`endif

    // Clamp the requested lag into 1..MAX_LAG.
    always_comb begin
        w_lag_eff = i_lag;
        if (i_lag == '0)
            w_lag_eff = LAG_W'(1);
        else if (i_lag > MAX_LAG_L)
            w_lag_eff = MAX_LAG_L;
    end

    assign w_hist_idx = w_lag_eff - LAG_W'(1);

    // r_lag resets to 0, which no effective lag can equal. The first cycle
    // after reset is therefore seen as a lag change while still in FILL: the
    // lag is latched and a sample on that cycle counts as fill sample 1,
    // exactly as if the lag had been stored at reset.
    always_ff @(posedge i_sysclk_40 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_FILL;
            r_cnt   <= '0;
            r_lag   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_lag   <= w_lag_eff;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_vld_next   = 1'b0;
        w_lag_chg    = (w_lag_eff != r_lag);
        // A lag change restarts the count; a sample on that same cycle is
        // fill sample 1 for the new lag.
        w_cnt_inc    = (w_lag_chg ? '0 : r_cnt) + LAG_W'(i_valid);

        case (r_state)
            S_FILL: begin
                if (i_valid && (w_cnt_inc >= w_lag_eff))
                    w_state_next = S_RUN;
            end
            S_RUN: begin
                if (w_lag_chg) begin
                    // Only reachable with a new lag of 1 and a sample present:
                    // the fill completes on this very sample.
                    if (i_valid && (w_cnt_inc >= w_lag_eff))
                        w_state_next = S_RUN;
                    else
                        w_state_next = S_FILL;
                end else begin
                    w_vld_next = i_valid;
                end
            end
            default: w_state_next = S_FILL;
        endcase

        w_cnt_next = (w_state_next == S_RUN) ? '0 : w_cnt_inc;
    end

    // Per-channel difference against the history tap selected by the lag.
    always_comb begin
        logic signed [DATA_WIDTH-1:0] v_x;
        logic signed [DATA_WIDTH-1:0] v_past;
        logic signed [DATA_WIDTH:0]   v_diff;
        w_deriv = '0;
`ifdef DERIV_SATURATE_EN
        w_clip  = 1'b0;
`endif
        for (int ch = 0; ch < NUM_CH; ch++) begin
            v_x    = i_data[ch*DATA_WIDTH +: DATA_WIDTH];
            v_past = '0;
            for (int j = 0; j < MAX_LAG; j++) begin
                if (w_hist_idx == LAG_W'(j))
                    v_past = r_hist[ch][j];
            end
            v_diff = {v_x[DATA_WIDTH-1], v_x} - {v_past[DATA_WIDTH-1], v_past};
            w_deriv[ch*DATA_WIDTH +: DATA_WIDTH] = reduce_diff(v_diff);
`ifdef DERIV_SATURATE_EN
            w_clip = w_clip | diff_clips(v_diff);
`endif
        end
    end

    // ---- stage p1: history shift and registered output ----
    always_ff @(posedge i_sysclk_40 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
`ifdef DERIV_SATURATE_EN
            r_sat_p1  <= 1'b0;
`endif
            for (int ch = 0; ch < NUM_CH; ch++)
                for (int j = 0; j < MAX_LAG; j++)
                    r_hist[ch][j] <= '0;
        end else begin
            r_vld_p1 <= w_vld_next;
            if (w_vld_next) begin
                r_data_p1 <= w_deriv;
`ifdef DERIV_SATURATE_EN
                r_sat_p1  <= w_clip;
`endif
            end
            if (i_valid) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    r_hist[ch][0] <= i_data[ch*DATA_WIDTH +: DATA_WIDTH];
                    for (int j = 1; j < MAX_LAG; j++)
                        r_hist[ch][j] <= r_hist[ch][j-1];
                end
            end
        end
    end

    assign o_valid           = r_vld_p1;
    assign o_derivative_data = r_data_p1;
    assign o_filling         = (r_state == S_FILL);
`ifdef DERIV_SATURATE_EN
    assign o_sat             = r_sat_p1;
`endif

endmodule

// File: tb/tb_derivative_lag_sv.sv
// ---------------------------------------------------------------------------
// tb_derivative_lag_sv
//
// Self-checking bench for derivative_lag_sv. A behavioural model tracks, per
// channel, the list of all accepted past samples and the number of valid
// samples seen since the lag was last (re)latched. A sample produces output
// when more than L samples have been seen since the latch; the block is
// filling while fewer than L have been seen.
// ---------------------------------------------------------------------------
module tb_derivative_lag_sv;

    localparam int DW  = 16;
    localparam int NCH = 2;
    localparam int ML  = 8;
    localparam int LW  = $clog2(ML + 1);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 i_valid;
    logic [NCH*DW-1:0]    i_data;
    logic [LW-1:0]        i_lag;
    logic                 o_valid;
    logic [NCH*DW-1:0]    o_derivative_data;
    logic                 o_filling;
`ifdef DERIV_SATURATE_EN
    logic                 o_sat;
`endif

    always #5 clk = ~clk;

    derivative_lag_sv #(.DATA_WIDTH(DW), .NUM_CH(NCH), .MAX_LAG(ML)) dut (
        .i_sysclk_40       (clk),
        .i_rst_n           (rst_n),
        .i_valid           (i_valid),
        .i_data            (i_data),
        .i_lag             (i_lag),
        .o_valid           (o_valid),
        .o_derivative_data (o_derivative_data),
`ifdef DERIV_SATURATE_EN
        .o_sat             (o_sat),
`endif
        .o_filling         (o_filling)
    );

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model state
    int               m_past [NCH][$];
    int               m_n;
    int               m_lag;
    logic [NCH*DW-1:0] m_out;
    logic             m_sat;
    logic             exp_vld;
    logic             exp_fill;

    function automatic int eff_lag(input int l);
        if (l == 0) return 1;
        if (l > ML) return ML;
        return l;
    endfunction

    function automatic logic [NCH*DW-1:0] pack2(input int a, input int b);
        logic [DW-1:0] la;
        logic [DW-1:0] lb;
        la = a[DW-1:0];
        lb = b[DW-1:0];
        return {lb, la};
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_past[ch].delete();
            for (int j = 0; j < ML; j++) m_past[ch].push_back(0);
        end
        m_n      = 0;
        m_lag    = -1;
        m_out    = '0;
        m_sat    = 1'b0;
        exp_vld  = 1'b0;
        exp_fill = 1'b1;
    endtask

    // Drive one cycle, advance the model, and land 1 time unit after the edge.
    task automatic step(input logic v, input logic [NCH*DW-1:0] d, input int lag);
        int L;
        int x;
        int df;
        logic [NCH*DW-1:0] o;
        logic sat_any;
        i_valid = v;
        i_data  = d;
        i_lag   = lag[LW-1:0];
        L = eff_lag(lag);
        if (L != m_lag) begin
            m_lag = L;
            m_n   = 0;
        end
        exp_vld = 1'b0;
        if (v) begin
            m_n++;
            exp_vld = (m_n > L);
            o = '0;
            sat_any = 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin
                x  = $signed(d[ch*DW +: DW]);
                df = x - m_past[ch][L-1];
`ifdef DERIV_SATURATE_EN
                if (df > 32767) begin
                    df = 32767; sat_any = 1'b1;
                end else if (df < -32768) begin
                    df = -32768; sat_any = 1'b1;
                end
`endif
                o[ch*DW +: DW] = df[DW-1:0];
                m_past[ch].push_front(x);
                m_past[ch].pop_back();
            end
            if (exp_vld) begin
                m_out = o;
                m_sat = sat_any;
            end
        end
        exp_fill = (m_n < L);
        @(posedge clk);
        #1;
    endtask

    // Assert reset between clock edges, hold two edges, release mid-cycle.
    task automatic pulse_reset();
        #2;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        i_lag   = LW'(2);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", o_valid); else n_pass++;
        n_chk++;
        if (o_derivative_data !== '0) $display("FAIL reset_data: got %h expected 0", o_derivative_data); else n_pass++;
        n_chk++;
        if (o_filling !== 1'b1) $display("FAIL reset_filling: got %b expected 1", o_filling); else n_pass++;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_fill_ramp();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, pack2(5*i, 5*i), 2);
            n_chk++;
            if ({o_valid, o_filling, o_derivative_data} !== {exp_vld, exp_fill, m_out})
                $display("FAIL ramp_s%0d: got vld=%b fill=%b data=%h expected vld=%b fill=%b data=%h",
                         i, o_valid, o_filling, o_derivative_data, exp_vld, exp_fill, m_out);
            else n_pass++;
            if (i == 1) begin
                n_chk++;
                if ({o_valid, o_filling} !== 2'b00)
                    $display("FAIL ramp_fill_drop: got vld=%b fill=%b expected 0/0", o_valid, o_filling);
                else n_pass++;
            end
            if (i >= 2) begin
                n_chk++;
                if ({o_valid, o_derivative_data} !== {1'b1, pack2(10, 10)})
                    $display("FAIL ramp_out%0d: got vld=%b data=%h expected 1/%h",
                             i, o_valid, o_derivative_data, pack2(10, 10));
                else n_pass++;
            end
        end
    endtask

    task automatic test_gapped();
        int k;
        int pulses;
        pulse_reset();
        k = 0;
        pulses = 0;
        for (int i = 0; i < 13; i++) begin
            if (i % 3 == 0) begin
                step(1'b1, pack2(5*k, 5*k), 2);
                k++;
            end else begin
                step(1'b0, 32'($urandom), 2);
            end
            if (o_valid === 1'b1) pulses++;
            n_chk++;
            if ({o_valid, o_filling, o_derivative_data} !== {exp_vld, exp_fill, m_out})
                $display("FAIL gapped_c%0d: got vld=%b fill=%b data=%h expected vld=%b fill=%b data=%h",
                         i, o_valid, o_filling, o_derivative_data, exp_vld, exp_fill, m_out);
            else n_pass++;
        end
        // Samples 3,4,5 produce output; data stays at 10 while held.
        n_chk++;
        if (pulses != 3) $display("FAIL gapped_pulses: got %0d expected 3", pulses); else n_pass++;
        n_chk++;
        if (o_derivative_data !== pack2(10, 10))
            $display("FAIL gapped_hold: got %h expected %h", o_derivative_data, pack2(10, 10));
        else n_pass++;
    endtask

    task automatic test_lag_change();
        int x;
        pulse_reset();
        x = 100;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, pack2(x, -x), 2);
            x += 5;
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, pack2(x, -x), 4);
            x += 5;
            n_chk++;
            if ({o_valid, o_filling, o_derivative_data} !== {exp_vld, exp_fill, m_out})
                $display("FAIL lagchg_s%0d: got vld=%b fill=%b data=%h expected vld=%b fill=%b data=%h",
                         i, o_valid, o_filling, o_derivative_data, exp_vld, exp_fill, m_out);
            else n_pass++;
            if (i < 4) begin
                n_chk++;
                if (o_valid !== 1'b0 || (i < 3 && o_filling !== 1'b1))
                    $display("FAIL lagchg_fill%0d: got vld=%b fill=%b expected 0/%b",
                             i, o_valid, o_filling, (i < 3));
                else n_pass++;
            end else begin
                n_chk++;
                if ({o_valid, o_derivative_data} !== {1'b1, pack2(20, -20)})
                    $display("FAIL lagchg_out%0d: got vld=%b data=%h expected 1/%h",
                             i, o_valid, o_derivative_data, pack2(20, -20));
                else n_pass++;
            end
        end
    endtask

    task automatic test_clamp();
        pulse_reset();
        step(1'b1, pack2(0, 0), 0);
        step(1'b1, pack2(5, 5), 0);
        n_chk++;
        if ({o_valid, o_derivative_data} !== {1'b1, pack2(5, 5)})
            $display("FAIL clamp_lag0: got vld=%b data=%h expected 1/%h", o_valid, o_derivative_data, pack2(5, 5));
        else n_pass++;
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, pack2(5*i, 5*i), 15);
            n_chk++;
            if ({o_valid, o_filling, o_derivative_data} !== {exp_vld, exp_fill, m_out})
                $display("FAIL clamp15_s%0d: got vld=%b fill=%b data=%h expected vld=%b fill=%b data=%h",
                         i, o_valid, o_filling, o_derivative_data, exp_vld, exp_fill, m_out);
            else n_pass++;
        end
        n_chk++;
        if ({o_valid, o_derivative_data} !== {1'b1, pack2(40, 40)})
            $display("FAIL clamp_lag15: got vld=%b data=%h expected 1/%h", o_valid, o_derivative_data, pack2(40, 40));
        else n_pass++;
    endtask

    task automatic test_overflow();
        pulse_reset();
        step(1'b1, {16'h8000, 16'h8000}, 1);
        step(1'b1, {16'h7FFF, 16'h7FFF}, 1);
`ifdef DERIV_SATURATE_EN
        n_chk++;
        if ({o_valid, o_sat, o_derivative_data} !== {2'b11, 32'h7FFF_7FFF})
            $display("FAIL ovf_pos: got vld=%b sat=%b data=%h expected 1/1/7fff7fff", o_valid, o_sat, o_derivative_data);
        else n_pass++;
`else
        n_chk++;
        if ({o_valid, o_derivative_data} !== {1'b1, 32'hFFFF_FFFF})
            $display("FAIL ovf_pos: got vld=%b data=%h expected 1/ffffffff", o_valid, o_derivative_data);
        else n_pass++;
`endif
        step(1'b1, {16'h8000, 16'h8000}, 1);
`ifdef DERIV_SATURATE_EN
        n_chk++;
        if ({o_valid, o_sat, o_derivative_data} !== {2'b11, 32'h8000_8000})
            $display("FAIL ovf_neg: got vld=%b sat=%b data=%h expected 1/1/80008000", o_valid, o_sat, o_derivative_data);
        else n_pass++;
`else
        n_chk++;
        if ({o_valid, o_derivative_data} !== {1'b1, 32'h0001_0001})
            $display("FAIL ovf_neg: got vld=%b data=%h expected 1/00010001", o_valid, o_derivative_data);
        else n_pass++;
`endif
    endtask

    task automatic test_random();
        int lag;
        pulse_reset();
        lag = 3;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) lag = int'($urandom_range(0, 15));
            step(($urandom_range(0, 9) < 6), 32'($urandom), lag);
            n_chk++;
            if ({o_valid, o_filling, o_derivative_data} !== {exp_vld, exp_fill, m_out})
                $display("FAIL random_c%0d: got vld=%b fill=%b data=%h expected vld=%b fill=%b data=%h (lag %0d)",
                         i, o_valid, o_filling, o_derivative_data, exp_vld, exp_fill, m_out, lag);
            else n_pass++;
`ifdef DERIV_SATURATE_EN
            if (exp_vld) begin
                n_chk++;
                if (o_sat !== m_sat) $display("FAIL random_sat%0d: got %b expected %b", i, o_sat, m_sat);
                else n_pass++;
            end
`endif
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) step(1'b1, pack2(7*i, 3*i), 3);
        n_chk++;
        if (o_valid !== 1'b1) $display("FAIL areset_pre: got vld=%b expected 1", o_valid); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({o_valid, o_filling, o_derivative_data} !== {1'b0, 1'b1, 32'h0})
            $display("FAIL areset_now: got vld=%b fill=%b data=%h expected 0/1/0", o_valid, o_filling, o_derivative_data);
        else n_pass++;
        i_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, pack2(1000 + 9*i, -2*i), 3);
            n_chk++;
            if ({o_valid, o_filling, o_derivative_data} !== {exp_vld, exp_fill, m_out})
                $display("FAIL areset_s%0d: got vld=%b fill=%b data=%h expected vld=%b fill=%b data=%h",
                         i, o_valid, o_filling, o_derivative_data, exp_vld, exp_fill, m_out);
            else n_pass++;
            if (i < 3) begin
                n_chk++;
                if (o_valid !== 1'b0) $display("FAIL areset_refill%0d: got vld=%b expected 0", i, o_valid);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_ramp();
        test_gapped();
        test_lag_change();
        test_clamp();
        test_overflow();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/derivative_lag_sv.md
Name: derivative_lag_sv

Overview:
- Multi-channel, valid-qualified discrete differentiator for the FM demodulator path.
- Per channel, computes y[n] = x[n] - x[n-L] with L selectable at run time from 1 to MAX_LAG.
- Sits between the decimated I/Q stream and the discriminator. With L=2 it produces the same difference as the existing single-channel derivative stage.
- Adds sample gating, a warm-up (fill) phase and optional saturation.

Parameters:
- DATA_WIDTH, 16: signed sample width per channel.
- NUM_CH, 2: number of independent channels (I and Q by default).
- MAX_LAG, 8: maximum supported lag. History depth per channel is MAX_LAG; must be >= 1.

Ports:
- i_sysclk_40  input  1  system clock, 40 MHz.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  qualifies i_data; one sample per channel per high cycle.
- i_data  input  NUM_CH*DATA_WIDTH  packed signed samples; channel k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_lag  input  $clog2(MAX_LAG+1)  requested lag L.
- o_valid  output  1  qualifies o_derivative_data.
- o_derivative_data  output  NUM_CH*DATA_WIDTH  packed signed differences, same packing as i_data.
- o_filling  output  1  high while in the FILL state.

Behaviour:
- Clock and reset: single clock i_sysclk_40. Reset i_rst_n is asynchronous assert, active-low, synchronous deassert handled upstream.
- Reset values: o_valid=0, o_derivative_data=0, o_filling=1, history=0, fill count=0, state=FILL, stored lag=effective lag of i_lag on the first post-reset cycle.
- Effective lag L:
  - i_lag=0 -> L=1.
  - i_lag>MAX_LAG -> L=MAX_LAG.
  - Otherwise L=i_lag.
- History: per-channel shift register hist[0..MAX_LAG-1], where hist[0] is the newest past sample. It shifts only on cycles with i_valid=1, when hist[0] <= x[n] and hist[j] <= hist[j-1].
- Difference: x[n] - hist[L-1], computed in DATA_WIDTH+1 bits, then reduced to DATA_WIDTH bits. Default reduction is wrap (keep the low DATA_WIDTH bits), matching existing modulo behaviour.
- Latency: exactly 1 cycle. o_valid is i_valid registered, gated by the state. Output data is registered and held when o_valid=0; data changes only on cycles where o_valid asserts.
- States:
  - FILL: o_filling=1 and o_valid=0. Each i_valid increments the fill count. When the count reaches L and i_valid=1, go to RUN; that sample itself produces no output. So the first output comes from sample L+1.
  - RUN: o_filling=0. Each i_valid produces o_valid=1 on the next cycle.
- Lag change: stored lag is compared with the effective i_lag every cycle. If they differ in RUN, go to FILL, clear the fill count and latch the new lag; history is kept. Any in-flight output on that cycle is suppressed (o_valid=0). A lag change in FILL restarts the count with the new lag.
- Simultaneous events:
  - Lag change and i_valid in the same cycle: the sample enters history and counts as fill sample 1 for the new lag.
  - i_valid gaps of any length: these are legal, and no state changes while i_valid=0.
- Reset mid-stream: all state and outputs return to reset values immediately, including mid-FILL.
- Channels share state, counter and lag; only the data paths are replicated.

Optional Feature:
- Macro: DERIV_SATURATE_EN.
- Defined: the DATA_WIDTH+1 difference saturates to the signed DATA_WIDTH range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Adds output o_sat (1 bit, reset 0), which is registered with o_valid and is high if any channel clipped on that sample.
- Undefined: wrap-around reduction, and no o_sat port.

Test Plan:
- Reset and fill: DATA_WIDTH=16, i_lag=2, ramp x=0,5,10,15 with i_valid every cycle.
  -> o_valid low for the first 2 samples and o_filling drops after the 2nd.
  -> Outputs 10,10 on channels 0 and 1, one cycle after samples 3 and 4.
- Gapped valid: same ramp with i_valid every 3rd cycle.
  -> Identical output sequence (10 each).
  -> o_valid pulses exactly 1 cycle after each valid input; data held between pulses.
- Lag change in RUN: steady ramp step 5, switch i_lag 2->4.
  -> o_valid low for the next 4 valid samples and o_filling=1.
  -> Then outputs of 20.
- Clamping: i_lag=0 gives output 5 after 1 fill sample. i_lag=15 with MAX_LAG=8 behaves as L=8 and gives output 40.
- Overflow: L=1, x[n-1]=0x8000, x[n]=0x7FFF.
  -> Without DERIV_SATURATE_EN: output 0xFFFF.
  -> With DERIV_SATURATE_EN: output 0x7FFF and o_sat=1.
  -> Reverse order (0x7FFF then 0x8000): 0x0001 wrapped, or 0x8000 with o_sat=1.
- Async reset mid-RUN: assert i_rst_n=0 between clock edges.
  -> Outputs go to 0 and o_filling to 1 immediately.
  -> After release, L fill samples are required again before o_valid.
